// File: rtl/fixedp_mac_acc.sv
// fixedp_mac_acc
//   Streaming fixed-point multiply-accumulate stage. It takes LEN signed operand
//   pairs (in1: Q WI1.WF1, in2: Q WI2.WF2) over a valid/ready handshake. Each pair
//   is multiplied at full precision into a registered product stage. The products
//   are summed into a guard-bit accumulator that cannot wrap. The sum is then
//   presented as a saturated Q WIO.WFO value over a valid/ready output handshake.
//
// Ports
//   CLK        in   1         system clock, rising edge
//   RST_N      in   1         synchronous active-low reset
//   in1        in   WI1+WF1   signed operand 1
//   in2        in   WI2+WF2   signed operand 2
//   in_valid   in   1         operand pair valid
//   in_ready   out  1         block can accept a pair (low while RST_N=0)
//   out        out  WIO+WFO   signed saturated result (0 outside DONE)
//   out_valid  out  1         out is valid
//   out_ready  in   1         consumer accepts out
//   OVF        out  1         out was saturated; qualified by out_valid
module fixedp_mac_acc #(
  parameter int WI1 = 5,
  parameter int WF1 = 4,
  parameter int WI2 = 7,
  parameter int WF2 = 3,
  parameter int WIO = 8,
  parameter int WFO = 4,
  parameter int LEN = 4
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic signed [WI1+WF1-1:0]   in1,
  input  logic signed [WI2+WF2-1:0]   in2,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic        [WIO+WFO-1:0]   out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        OVF
);

  localparam int W1  = WI1 + WF1;
  localparam int W2  = WI2 + WF2;
  localparam int WO  = WIO + WFO;
  localparam int PW  = W1 + W2;              // full-precision product width
  localparam int G   = $clog2(LEN);          // guard bits so LEN products never wrap
  localparam int AW  = PW + G;
  localparam int WFA = WF1 + WF2;            // fraction bits of product and acc
  localparam int SHR = (WFA > WFO) ? (WFA - WFO) : 0;
  localparam int SHL = (WFO > WFA) ? (WFO - WFA) : 0;
  localparam int EW  = AW + SHL + WO;        // headroom so the range compare is exact
  localparam int CW  = $clog2(LEN + 1);

  localparam logic [CW-1:0] LEN_C = CW'(LEN);
  localparam logic signed [EW-1:0] OMAX = {{(EW-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [EW-1:0] OMIN = {{(EW-WO+1){1'b1}}, {(WO-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [PW-1:0]    p_q, p_d;
  logic                    p_vld_q, p_vld_d;
  logic        [CW-1:0]    cnt_q, cnt_d;
  logic        [WO-1:0]    out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    ovf_q, ovf_d;
  logic                    hs_s;
  logic                    out_hs_s;
  logic signed [EW-1:0]    scaled_s;
  logic        [WO:0]      conv_s;

  // Clamp a rescaled value into Q WIO.WFO; the top bit flags saturation.
  function automatic logic [WO:0] sat_conv(input logic signed [EW-1:0] v);
    if (v > OMAX) begin
      sat_conv = {1'b1, OMAX[WO-1:0]};
    end else if (v < OMIN) begin
      sat_conv = {1'b1, OMIN[WO-1:0]};
    end else begin
      sat_conv = {1'b0, v[WO-1:0]};
    end
  endfunction

  // in_ready is gated by RST_N so that no pair is taken while reset is asserted.
  assign in_ready  = RST_N && ((state_q == S_IDLE) || (state_q == S_ACC));
  assign hs_s      = in_valid && in_ready;
  assign out_hs_s  = out_valid_q && out_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign OVF       = ovf_q;

  // Format conversion from the accumulator: the arithmetic right shift truncates toward -inf.
  always_comb begin
    scaled_s = (EW'(acc_q) <<< SHL) >>> SHR;
    conv_s   = sat_conv(scaled_s);
  end

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_vld_d = hs_s;
    if (hs_s) begin
      p_d = PW'(in1) * PW'(in2);
    end else begin
      p_d = p_q;
    end
    if (p_vld_q) begin
      acc_d = acc_q + AW'(p_q);
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      S_IDLE: begin
        if (hs_s) begin
          cnt_d   = CW'(1);
          state_d = S_ACC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        if (hs_s) begin
          cnt_d = cnt_q + CW'(1);
          if ((cnt_q + CW'(1)) == LEN_C) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ACC;
          end
        end else begin
          state_d = S_ACC;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        // The result must be visible (out_valid_q) before a handshake can release it.
        if (out_hs_s) begin
          state_d = S_IDLE;
          acc_d   = {AW{1'b0}};
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The result registers load one edge after DONE is entered, when acc already holds the final sum.
    out_valid_d = (state_q == S_DONE) && !out_hs_s;
    if (out_valid_d) begin
      out_d = conv_s[WO-1:0];
      ovf_d = conv_s[WO];
    end else begin
      out_d = {WO{1'b0}};
      ovf_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      acc_q       <= {AW{1'b0}};
      p_q         <= {PW{1'b0}};
      p_vld_q     <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      out_q       <= {WO{1'b0}};
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      p_vld_q     <= p_vld_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fixedp_mac_acc.sv
// Self-checking bench for fixedp_mac_acc (Q5.4 x Q7.3 -> Q8.4, LEN=4).
// When the 4th pair of a group is accepted, the expected results are pushed to a
// queue. They are popped and compared when the DUT presents out_valid.
module tb_fixedp_mac_acc;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [8:0]  in1 = 9'h000;
  logic [9:0]  in2 = 10'h000;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        OVF;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [12:0] exp_q[$];   // {ovf, out}

  fixedp_mac_acc dut (
    .CLK(CLK), .RST_N(RST_N), .in1(in1), .in2(in2), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // The sum is in 2^-7 units. Floor to 2^-4, then saturate to the signed 12-bit range.
  function automatic logic [12:0] model(input longint sum7);
    longint s;
    logic [63:0] u;
    s = sum7 >>> 3;
    u = s;
    if (s > 2047) return {1'b1, 12'h7FF};
    else if (s < -2048) return {1'b1, 12'h800};
    else return {1'b0, u[11:0]};
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic drive_pair(input logic [8:0] a, input logic [9:0] b);
    bit done = 1'b0;
    in1 = a; in2 = b; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK); done = in_ready;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total_cnt++;
      $display("FAIL drive_timeout: in_ready=0 required=1");
    end
  endtask

  task automatic send_group(input logic [8:0] a, input logic [9:0] b, input int gap);
    longint s = 0;
    for (int k = 0; k < 4; k++) begin
      drive_pair(a, b);
      s += longint'($signed(a)) * longint'($signed(b));
      if (k < 3) repeat (gap) tick();
    end
    exp_q.push_back(model(s));
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; in_valid = 1'b1;
    @(negedge CLK);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out !== 12'h000) $display("FAIL rst_out: got %h expected 000", out); else pass_cnt++;
    total_cnt++; if (OVF !== 1'b0) $display("FAIL rst_ovf: got %b expected 0", OVF); else pass_cnt++;
    RST_N = 1'b1; in_valid = 1'b0;
    tick();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [12:0] e;
    send_group(9'h010, 10'h010, 0);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL lat_t0: out_valid=%b expected 0", out_valid); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL lat_t1: out_valid=%b expected 0", out_valid); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL lat_t2: out_valid=%b expected 1", out_valid); else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++; if (out !== e[11:0]) $display("FAIL basic_out: got %h expected %h", out, e[11:0]); else pass_cnt++;
    total_cnt++; if (OVF !== e[12]) $display("FAIL basic_ovf: got %b expected %b", OVF, e[12]); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL done_in_ready: got %b expected 0", in_ready); else pass_cnt++;
    release_out();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_release: out_valid=%b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_reready: in_ready=%b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_saturation_truncation();
    logic [8:0] ta [4] = '{9'h0FF, 9'h100, 9'h001, 9'h1FF};
    logic [9:0] tb_ [4] = '{10'h1FF, 10'h1FF, 10'h001, 10'h001};
    logic [12:0] e;
    bit ok;
    for (int c = 0; c < 4; c++) begin
      send_group(ta[c], tb_[c], 0);
      wait_valid(ok);
      e = exp_q.pop_front();
      if (!ok) begin
        total_cnt++; $display("FAIL sat_case%0d_timeout: out_valid=0 expected 1", c);
      end else begin
        total_cnt++; if (out !== e[11:0]) $display("FAIL sat_case%0d_out: got %h expected %h", c, out, e[11:0]); else pass_cnt++;
        total_cnt++; if (OVF !== e[12]) $display("FAIL sat_case%0d_ovf: got %b expected %b", c, OVF, e[12]); else pass_cnt++;
      end
      release_out();
    end
  endtask

  task automatic test_stall();
    logic [12:0] e;
    bit ok;
    send_group(9'h010, 10'h010, 2);
    wait_valid(ok);
    e = exp_q.pop_front();
    total_cnt++; if (!ok) $display("FAIL stall_timeout: out_valid=0 expected 1"); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in1 = 9'h0AA; in2 = 10'h055;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready%0d: got %b expected 0", i, in_ready); else pass_cnt++;
      total_cnt++; if ({out_valid, OVF, out} !== {1'b1, e}) $display("FAIL stall_hold%0d: got %b/%b/%h expected 1/%b/%h", i, out_valid, OVF, out, e[12], e[11:0]); else pass_cnt++;
      tick();
    end
    in_valid = 1'b0;
    release_out();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL stall_reready: got %b expected 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_release: out_valid=%b expected 0", out_valid); else pass_cnt++;
    send_group(9'h010, 10'h010, 0);
    wait_valid(ok);
    e = exp_q.pop_front();
    total_cnt++; if (!ok || out !== e[11:0]) $display("FAIL stall_fresh: got %h expected %h", out, e[11:0]); else pass_cnt++;
    release_out();
  endtask

  task automatic test_midreset();
    logic [12:0] e;
    bit ok;
    drive_pair(9'h010, 10'h010);
    drive_pair(9'h010, 10'h010);
    RST_N = 1'b0;
    @(negedge CLK);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL mrst_in_ready: got %b expected 0", in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mrst_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    RST_N = 1'b1;
    send_group(9'h010, 10'h010, 0);
    wait_valid(ok);
    e = exp_q.pop_front();
    total_cnt++; if (!ok || out !== e[11:0]) $display("FAIL mrst_result: got %h expected %h", out, e[11:0]); else pass_cnt++;
    total_cnt++; if (OVF !== e[12]) $display("FAIL mrst_ovf: got %b expected %b", OVF, e[12]); else pass_cnt++;
    release_out();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    fork
      begin
        for (int g = 0; g < 3; g++) begin
          longint s = 0;
          for (int k = 0; k < 4; k++) begin
            logic [8:0] a;
            logic [9:0] b;
            int v;
            a = 9'($urandom_range(0, 511));
            v = $urandom_range(0, 31) - 16;
            b = v[9:0];
            drive_pair(a, b);
            s += longint'($signed(a)) * longint'($signed(b));
          end
          exp_q.push_back(model(s));
        end
      end
      begin
        for (int r = 0; r < 3; r++) begin
          bit got = 1'b0;
          logic [12:0] e;
          for (int i = 0; i < 80 && !got; i++) begin
            @(negedge CLK);
            if (out_valid) got = 1'b1;
          end
          if (!got || exp_q.size() == 0) begin
            total_cnt++; $display("FAIL b2b_timeout%0d: out_valid=%b queued=%0d", r, out_valid, exp_q.size());
          end else begin
            e = exp_q.pop_front();
            total_cnt++; if ({OVF, out} !== e) $display("FAIL b2b_result%0d: got %b/%h expected %b/%h", r, OVF, out, e[12], e[11:0]); else pass_cnt++;
          end
        end
      end
    join
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation_truncation();
    test_stall();
    test_midreset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
